fx3_stream_out_rx: RTL

//  FPGA-side receiver for the FX3 host-to-device (stream-out) path; the opposite direction of the stream-in transmitter.
//  The FX3 pushes fixed-length bursts (one per DMA thread, alternating TH0/TH1) whenever fx3_space_available is high.

---
 rtl/fx3_stream_out_rx.sv | 100 ++++++++++
 1 files changed

// File: rtl/fx3_stream_out_rx.sv
// fx3_stream_out_rx: FX3 stream-out (host-to-device) receiver that takes fixed-length
// bursts from the FX3, buffers them in a FIFO, and forwards them as AXI4-Stream.
//  clk_out             interface clock shared with the FX3 GPIF
//  aresetn             sync active-low reset of all state
//  fx3_resetn          sync active-low link reset; clears everything except burst_count
//  fx3_data            FX3 write data, qualified by fx3_write_valid
//  fx3_write_valid     FX3 drives one word this cycle
//  fx3_space_available FIFO can take a whole burst; FX3 may start
//  fx3_thread          DMA thread expected for the next/current burst
//  m_tdata/m_tvalid/m_tready/m_tlast  AXI4-Stream master, tlast on last word of a burst
//  overflow            sticky: accepted word hit a full FIFO
//  protocol_err        sticky: word arrived while a burst could not be accepted
//  burst_count         completed bursts, wrapping
module fx3_stream_out_rx #(
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 4092,
  parameter int FIFO_AW   = 13
) (
  input  logic              clk_out,
  input  logic              aresetn,
  input  logic              fx3_resetn,
  input  logic [DATA_W-1:0] fx3_data,
  input  logic              fx3_write_valid,
  output logic              fx3_space_available,
  output logic              fx3_thread,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              overflow,
  output logic              protocol_err,
  output logic [31:0]       burst_count
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = $clog2(BURST_LEN + 1);
  typedef enum logic [1:0] {S_IDLE, S_RECV, S_DONE} state_t;
  state_t            state;
  logic              rst;
  logic [DATA_W:0]   mem [DEPTH];
  logic [DATA_W:0]   rd_word;
  logic [FIFO_AW:0]  wr_ptr, rd_ptr, fill, free_words;
  logic [CW-1:0]     word_cnt;
  logic              r_valid, r_last;
  logic [DATA_W-1:0] r_data;
  logic              accept, last, push, pop, load;
  assign rst        = !aresetn || !fx3_resetn;
  // fill counts every word held, including the one parked in the AXIS output register,
  // so total capacity is exactly DEPTH words
  assign free_words = (FIFO_AW+1)'(DEPTH) - fill;
  // decisions are made on the raw input at the sample edge; stage R carries them to the FIFO write
  assign accept     = fx3_write_valid && ((state == S_IDLE && fx3_space_available) || state == S_RECV);
  assign last       = word_cnt == CW'(BURST_LEN - 1);
  assign push       = r_valid && fill != (FIFO_AW+1)'(DEPTH);
  assign pop        = m_tvalid && m_tready;
  assign load       = wr_ptr != rd_ptr && (!m_tvalid || m_tready);
  assign rd_word    = mem[rd_ptr[FIFO_AW-1:0]];
  always_ff @(posedge clk_out)
    if (push) mem[wr_ptr[FIFO_AW-1:0]] <= {r_last, r_data};
  always_ff @(posedge clk_out) begin
    if (rst) begin
      state               <= S_IDLE;
      word_cnt            <= '0;
      fx3_space_available <= 1'b0;
      fx3_thread          <= 1'b0;
      r_valid             <= 1'b0;
      r_last              <= 1'b0;
      r_data              <= '0;
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      fill                <= '0;
      m_tdata             <= '0;
      m_tvalid            <= 1'b0;
      m_tlast             <= 1'b0;
      overflow            <= 1'b0;
      protocol_err        <= 1'b0;
    end else begin
      r_valid             <= accept;
      r_last              <= accept && last;
      r_data              <= fx3_data;
      word_cnt            <= state == S_DONE ? '0 : word_cnt + CW'(accept);
      state               <= state == S_DONE ? S_IDLE : accept ? (last ? S_DONE : S_RECV) : state;
      fx3_thread          <= fx3_thread ^ (state == S_DONE);
      fx3_space_available <= state == S_IDLE && !accept && free_words >= (FIFO_AW+1)'(BURST_LEN);
      if (fx3_write_valid && !accept) protocol_err <= 1'b1;
      if (r_valid && !push) overflow <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) rd_ptr <= rd_ptr + 1'b1;
      fill                <= fill + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
      if (load) begin
        m_tdata <= rd_word[DATA_W-1:0];
        m_tlast <= rd_word[DATA_W];
      end
      m_tvalid            <= load || (m_tvalid && !m_tready);
    end
  end
  // a link reset must not lose the throughput history, so only aresetn clears the count
  always_ff @(posedge clk_out)
    if (!aresetn) burst_count <= '0;
    else if (fx3_resetn && state == S_DONE) burst_count <= burst_count + 32'd1;
endmodule
